// File: rtl/whirl_pkg.sv
// Shared Whirlpool round definitions: block geometry, sequencer states and
// the byte-granular row rotation used when folding table results together.
package whirl_pkg;

  localparam int ROWS  = 8;
  localparam int ROW_W = 64;
  localparam int BLK_W = ROWS * ROW_W;
  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Rotate a 64-bit row right by a whole number of bytes.
  function automatic logic [ROW_W-1:0] rotr64(input logic [ROW_W-1:0] x,
                                              input logic [2:0]       nbytes);
    return (x >> (8 * nbytes)) | (x << (ROW_W - 8 * nbytes));
  endfunction

endpackage

// File: rtl/whirl_sbox.sv
// Whirlpool C0 lookup: S-box built from the E, E^-1 and R mini-boxes, expanded
// by the circulant row (1,1,4,1,8,5,2,9) over GF(2^8)/0x11D, one-cycle registered.
module whirl_sbox
  import whirl_pkg::*;
(
  input  logic             i_clk,
  input  logic [7:0]       i_addr,
  output logic [ROW_W-1:0] o_data
);

  localparam logic [63:0] E_TAB  = 64'h1B9CD6F3E874A250;
  localparam logic [63:0] EI_TAB = 64'hF0D7BE5A92C13486;
  localparam logic [63:0] R_TAB  = 64'h7CBDE49F638A2510;

  function automatic logic [3:0] nib(input logic [63:0] tab, input logic [3:0] x);
    return tab[63 - 4 * int'(x) -: 4];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  logic [3:0]       hi_e, lo_ei, mix;
  logic [7:0]       s1, s2, s4, s8;
  logic [ROW_W-1:0] row;

  always_comb begin
    hi_e  = nib(E_TAB, i_addr[7:4]);
    lo_ei = nib(EI_TAB, i_addr[3:0]);
    mix   = nib(R_TAB, hi_e ^ lo_ei);
    s1    = {nib(E_TAB, hi_e ^ mix), nib(EI_TAB, lo_ei ^ mix)};
    s2    = xtime(s1);
    s4    = xtime(s2);
    s8    = xtime(s4);
    row   = {s1, s1, s4, s1, s8, s4 ^ s1, s2, s8 ^ s1};
  end

  // NOTE: the lookup register has no reset; the sequencer's valid flag decides whether its contents are used.
  always_ff @(posedge i_clk) begin
    o_data <= row;
  end

endmodule

// File: rtl/whirl_round_seq.sv
// Sequential Whirlpool round: 64 C0 lookups folded into eight row accumulators.
// Build option WHIRL_ROUND_SEQ_DUAL_EN: two lookup lanes, two indices per cycle.
module whirl_round_seq
  import whirl_pkg::*;
#(
  parameter int DLY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [BLK_W-1:0] i_state,
  input  logic [BLK_W-1:0] i_key,
  output logic             o_busy,
  output logic             o_done,
  output logic [BLK_W-1:0] o_state
);

`ifdef WHIRL_ROUND_SEQ_DUAL_EN
  localparam int LANES = 2;
`else
  localparam int LANES = 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(64 - LANES);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

  if (DLY < 0) begin : g_dly_chk
    $error("DLY must be non-negative");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             issued_q, issued_d;
  logic             vld_q, vld_d;
  logic [ROW_W-1:0] acc_q [ROWS];
  logic [ROW_W-1:0] acc_d [ROWS];
  logic [BLK_W-1:0] ost_q, ost_d;
  logic             done_q, done_d;
  logic [BLK_W-1:0] blk_q, key_q;
  logic             accept;

  // Row/column tags follow each lookup through the table's register stage.
  logic [2:0]       lane_row [LANES];
  logic [2:0]       lane_col [LANES];
  logic [2:0]       row_q    [LANES];
  logic [2:0]       col_q    [LANES];
  logic [7:0]       addr     [LANES];
  logic [ROW_W-1:0] tdata    [LANES];

  assign accept = (state_q == ST_IDLE) && i_start;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0] k;
    logic [2:0]       src;

    assign k           = idx_q + IDX_W'(l);
    assign lane_row[l] = k[5:3];
    assign lane_col[l] = k[2:0];
    assign src         = k[5:3] - k[2:0];
    assign addr[l]     = blk_q[BLK_W - 1 - ROW_W * int'(src) - 8 * int'(k[2:0]) -: 8];

    whirl_sbox u_sbox (
      .i_clk  (i_clk),
      .i_addr (addr[l]),
      .o_data (tdata[l])
    );
  end

  // NOTE: every next-state variable takes its hold value first, so no path leaves one unassigned and no latch appears.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    issued_d = issued_q;
    vld_d    = 1'b0;
    acc_d    = acc_q;
    ost_d    = ost_q;
    done_d   = 1'b0;

    if (vld_q) begin
      for (int l = 0; l < LANES; l++) begin
        acc_d[row_q[l]] = acc_d[row_q[l]] ^ rotr64(tdata[l], col_q[l]);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_RUN;
          idx_d    = '0;
          issued_d = 1'b0;
          for (int r = 0; r < ROWS; r++) acc_d[r] = '0;
        end
      end
      ST_RUN: begin
        if (!issued_q) begin
          vld_d = 1'b1;
          if (idx_q == LAST_IDX) issued_d = 1'b1;
          else                   idx_d    = idx_q + IDX_STEP;
        end else begin
          // The final lookup folds in on this edge.
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        for (int r = 0; r < ROWS; r++) begin
          ost_d[BLK_W - 1 - ROW_W * r -: ROW_W] =
            acc_q[r] ^ key_q[BLK_W - 1 - ROW_W * r -: ROW_W];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      issued_q <= 1'b0;
      vld_q    <= 1'b0;
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
      ost_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      issued_q <= issued_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
      ost_q    <= ost_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      blk_q <= i_state;
      key_q <= i_key;
    end
    row_q <= lane_row;
    col_q <= lane_col;
  end

  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = done_q;
  assign o_state = ost_q;

endmodule

// File: tb/tb_whirl_round_seq.sv
// Directed and model-based checks of whirl_round_seq in either lane build.
module tb_whirl_round_seq;

`ifdef WHIRL_ROUND_SEQ_DUAL_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 66;
`endif

  logic         clk, rst, start;
  logic [511:0] st_in, key_in, o_st;
  logic         busy, done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string        name;
    logic [511:0] st;
    logic [511:0] key;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs [6];

  whirl_round_seq #(.DLY(1)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_state (st_in),
    .i_key   (key_in),
    .o_busy  (busy),
    .o_done  (done),
    .o_state (o_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[479:0], $urandom()};
    return v;
  endfunction

  // Reference round: S-box from mini-boxes, then explicit GF(2^8) products.
  function automatic logic [3:0] m_e(input logic [3:0] x);
    logic [3:0] t [16] = '{4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
                           4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0};
    return t[x];
  endfunction

  function automatic logic [3:0] m_ei(input logic [3:0] x);
    logic [3:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) if (m_e(4'(i)) == x) res = 4'(i);
    return res;
  endfunction

  function automatic logic [3:0] m_r(input logic [3:0] x);
    logic [3:0] t [16] = '{4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
                           4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0};
    return t[x];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [3:0] a, b, r;
    a = m_e(x[7:4]);
    b = m_ei(x[3:0]);
    r = m_r(a ^ b);
    return {m_e(a ^ r), m_ei(b ^ r)};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [511:0] model(input logic [511:0] s, input logic [511:0] k);
    logic [7:0]   mv [8] = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};
    logic [511:0] o;
    logic [7:0]   acc, b;
    o = k;
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 8; j++) begin
        acc = '0;
        for (int c = 0; c < 8; c++) begin
          b   = s[511 - 64 * ((r - c + 8) % 8) - 8 * c -: 8];
          acc ^= gmul(m_sbox(b), mv[(j - c + 8) % 8]);
        end
        o[511 - 64 * r - 8 * j -: 8] ^= acc;
      end
    end
    return o;
  endfunction

  task automatic wait_done(input int n0, input int limit, output int n, output bit ovl);
    n   = -1;
    ovl = 1'b0;
    for (int i = n0 + 1; i <= limit; i++) begin
      tick();
      if (busy && done) ovl = 1'b1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_round(input string name, input logic [511:0] s, input logic [511:0] k,
                           input logic [511:0] exp, input bit detail);
    int n;
    bit ovl;
    st_in  = s;
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    if (detail) check({name, " busy after accept"}, busy, 1'b1);
    wait_done(0, LAT + 8, n, ovl);
    check({name, " latency"}, n, LAT);
    check({name, " result"}, o_st, exp);
    if (detail) begin
      check({name, " busy/done overlap"}, ovl, 1'b0);
      tick();
      check({name, " done pulse width"}, done, 1'b0);
      check({name, " idle after done"}, busy, 1'b0);
      repeat (2) tick();
      check({name, " result held"}, o_st, exp);
    end
  endtask

  initial begin
    int  n;
    bit  ovl;
    logic [511:0] s, k, rkey;

    rkey = rand512();
    vecs[0] = '{"zero", '0, '0, {64{8'h28}}};
    vecs[1] = '{"key_ff", '0, {64{8'hFF}}, {64{8'hD7}}};
    vecs[2] = '{"t_zero", {64{8'h81}}, rkey, rkey};
    vecs[3] = '{"all_01", {64{8'h01}}, '0, {64{8'h65}}};
    vecs[4] = '{"row0_01", {{8{8'h01}}, 448'h0}, '0,
                512'h1313c413edff5ed6_d61313c413edff5e_5ed61313c413edff_ff5ed61313c413ed_edff5ed61313c413_13edff5ed61313c4_c413edff5ed61313_13c413edff5ed613};
    vecs[5] = '{"row0_01_kff", {{8{8'h01}}, 448'h0}, {64{8'hFF}}, ~vecs[4].exp};

    rst = 1'b1; start = 1'b0; st_in = '0; key_in = '0;
    repeat (3) tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset o_state", o_st, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_round(vecs[i].name, vecs[i].st, vecs[i].key, vecs[i].exp, 1'b1);

    // Reset on cycle 30 of a round, then a fresh zero round.
    st_in = rand512(); key_in = rand512(); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    check("midreset o_state", o_st, '0);
    wait_done(0, 80, n, ovl);
    check("aborted round done", n, -1);
    run_round("restart", '0, '0, {64{8'h28}}, 1'b1);

    // Start and input changes while running are ignored.
    st_in = vecs[4].st; key_in = vecs[4].key; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1; st_in = {64{8'hFF}}; key_in = rand512();
    repeat (3) tick();
    start = 1'b0;
    wait_done(13, LAT + 8, n, ovl);
    check("midrun latency", n, LAT);
    check("midrun result", o_st, vecs[4].exp);
    tick();

    // Start held high: second round begins right after the first finishes.
    st_in = '0; key_in = '0; start = 1'b1;
    tick();
    wait_done(0, LAT + 8, n, ovl);
    check("b2b first latency", n, LAT);
    wait_done(0, LAT + 10, n, ovl);
    start = 1'b0;
    check("b2b gap", n, LAT + 1);
    check("b2b result", o_st, {64{8'h28}});
    repeat (2) tick();
    check("b2b no third round", busy, 1'b0);

    for (int i = 0; i < 200; i++) begin
      s = rand512();
      k = rand512();
      run_round($sformatf("rand%0d", i), s, k, model(s, k), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
